// File: rtl/rename_cap_gate.sv
// Rename front with capability-uop tagging, in-flight credit gating and a
// single-entry valid/ready dispatch register; keeps saturating statistics.

package rename_cap_pkg;

  typedef enum logic [3:0] {
    UOP_NOP                = 4'd0,
    UOP_ALU                = 4'd1,
    UOP_LOAD               = 4'd2,
    UOP_STORE              = 4'd3,
    UOP_BRANCH             = 4'd4,
    UOP_PREFIX_SELECT      = 4'd5,
    UOP_PREFIX_CANCEL      = 4'd6,
    UOP_CAP_CLONE_RESTRICT = 4'd7,
    UOP_CAP_LOAN_BEGIN     = 4'd8,
    UOP_CAP_LOAN_END       = 4'd9,
    UOP_CAP_JUMP           = 4'd10,
    UOP_CAP_RET            = 4'd11,
    UOP_LINK               = 4'd12
  } uop_tag_t;

  // Capability uops are the ones counted against the in-flight budget.
  function automatic logic is_capability(input uop_tag_t tag);
    case (tag)
      UOP_PREFIX_SELECT,
      UOP_PREFIX_CANCEL,
      UOP_CAP_CLONE_RESTRICT,
      UOP_CAP_LOAN_BEGIN,
      UOP_CAP_LOAN_END,
      UOP_CAP_JUMP,
      UOP_CAP_RET,
      UOP_LINK:  return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

module rename_cap_gate
  import rename_cap_pkg::*;
#(
  parameter int unsigned LANES            = 4,
  parameter int unsigned CAP_INFLIGHT_MAX = 8,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   decode_valid_i,
  input  uop_tag_t [LANES-1:0]                   decode_uops_i,
  input  logic [$clog2(LANES+1)-1:0]             decode_uop_count_i,
  output logic                                   rename_ready_o,
  output logic                                   dispatch_valid_o,
  input  logic                                   dispatch_ready_i,
  output uop_tag_t [LANES-1:0]                   dispatch_uops_o,
  output logic [LANES-1:0]                       dispatch_lane_valid_o,
  output logic [LANES-1:0]                       lane_is_capability_o,
  input  logic [$clog2(LANES+1)-1:0]             cap_retire_i,
  input  logic                                   flush_i,
  output logic [$clog2(CAP_INFLIGHT_MAX+1)-1:0]  cap_inflight_o,
  output logic [CNT_W-1:0]                       cap_issued_count_o,
  output logic [CNT_W-1:0]                       stall_cycles_o,
  output logic                                   retire_underflow_o
);

  localparam int unsigned CW = $clog2(LANES + 1);
  localparam int unsigned IW = $clog2(CAP_INFLIGHT_MAX + 1);
  // Headroom for inflight + caps before the budget compare.
  localparam int unsigned SW = ((IW > CW) ? IW : CW) + 1;

  logic [CW-1:0]        n_c;
  logic [LANES-1:0]     lane_valid_c;
  logic [LANES-1:0]     cap_mask_c;
  uop_tag_t [LANES-1:0] uops_masked_c;
  logic [SW-1:0]        caps_c;
  logic [SW-1:0]        ret_c;
  logic                 underflow_c;
  logic                 credit_ok_c;
  logic                 slot_free_c;
  logic                 accept_c;
  logic                 stall_c;
  logic [IW-1:0]        inflight_next_c;
  logic [CNT_W:0]       issued_sum_c;

  // Lane decode, credit check and handshake qualification.
  always_comb begin
    n_c           = (decode_uop_count_i > CW'(LANES)) ? CW'(LANES) : decode_uop_count_i;
    lane_valid_c  = '0;
    cap_mask_c    = '0;
    caps_c        = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_valid_c[i]  = CW'(i) < n_c;
      cap_mask_c[i]    = lane_valid_c[i] & is_capability(decode_uops_i[i]);
      uops_masked_c[i] = lane_valid_c[i] ? decode_uops_i[i] : UOP_NOP;
      caps_c           = caps_c + SW'(cap_mask_c[i]);
    end

    underflow_c     = SW'(cap_retire_i) > SW'(cap_inflight_o);
    ret_c           = underflow_c ? SW'(cap_inflight_o) : SW'(cap_retire_i);
    credit_ok_c     = (SW'(cap_inflight_o) - ret_c + caps_c) <= SW'(CAP_INFLIGHT_MAX);
    slot_free_c     = !dispatch_valid_o || dispatch_ready_i;
    rename_ready_o  = !rst_i && !flush_i && slot_free_c && credit_ok_c;
    accept_c        = decode_valid_i && rename_ready_o;
    stall_c         = decode_valid_i && !rename_ready_o && !flush_i;
    inflight_next_c = IW'(SW'(cap_inflight_o) - ret_c + (accept_c ? caps_c : SW'(0)));
    issued_sum_c    = {1'b0, cap_issued_count_o} + (CNT_W+1)'(caps_c);
  end

  // Dispatch register, in-flight tracking and statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dispatch_valid_o      <= 1'b0;
      dispatch_lane_valid_o <= '0;
      lane_is_capability_o  <= '0;
      for (int unsigned i = 0; i < LANES; i++) dispatch_uops_o[i] <= UOP_NOP;
      cap_inflight_o        <= '0;
      cap_issued_count_o    <= '0;
      stall_cycles_o        <= '0;
      retire_underflow_o    <= 1'b0;
    end else if (flush_i) begin
      // Flushed uops never retire, so the budget restarts from zero.
      dispatch_valid_o      <= 1'b0;
      dispatch_lane_valid_o <= '0;
      lane_is_capability_o  <= '0;
      for (int unsigned i = 0; i < LANES; i++) dispatch_uops_o[i] <= UOP_NOP;
      cap_inflight_o        <= '0;
    end else begin
      cap_inflight_o <= inflight_next_c;
      if (underflow_c) retire_underflow_o <= 1'b1;
      if (stall_c && (stall_cycles_o != '1)) stall_cycles_o <= stall_cycles_o + CNT_W'(1);

      if (accept_c) begin
        dispatch_valid_o      <= n_c != '0;
        dispatch_lane_valid_o <= lane_valid_c;
        lane_is_capability_o  <= cap_mask_c;
        dispatch_uops_o       <= uops_masked_c;
        cap_issued_count_o    <= issued_sum_c[CNT_W] ? '1 : issued_sum_c[CNT_W-1:0];
      end else if (dispatch_valid_o && dispatch_ready_i) begin
        dispatch_valid_o      <= 1'b0;
        dispatch_lane_valid_o <= '0;
        lane_is_capability_o  <= '0;
        for (int unsigned i = 0; i < LANES; i++) dispatch_uops_o[i] <= UOP_NOP;
      end
    end
  end

endmodule

// File: tb/tb_rename_cap_gate.sv
// Directed bench for rename_cap_gate: stimulus pushes expected dispatch bundles,
// a negedge monitor pops and compares them on each dispatch handshake.

module tb_rename_cap_gate;
  import rename_cap_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           dv;
  uop_tag_t [3:0] duops;
  logic [2:0]     dcnt;
  logic           rr;
  logic           disp_v;
  logic           disp_rdy;
  uop_tag_t [3:0] disp_uops;
  logic [3:0]     disp_lv;
  logic [3:0]     disp_cap;
  logic [2:0]     ret;
  logic           flush;
  logic [3:0]     inflight;
  logic [15:0]    issued;
  logic [15:0]    stall;
  logic           unf;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [15:0] u;
    logic [3:0]  lv;
    logic [3:0]  cm;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rename_cap_gate #(.LANES(4), .CAP_INFLIGHT_MAX(8), .CNT_W(16)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .decode_valid_i        (dv),
    .decode_uops_i         (duops),
    .decode_uop_count_i    (dcnt),
    .rename_ready_o        (rr),
    .dispatch_valid_o      (disp_v),
    .dispatch_ready_i      (disp_rdy),
    .dispatch_uops_o       (disp_uops),
    .dispatch_lane_valid_o (disp_lv),
    .lane_is_capability_o  (disp_cap),
    .cap_retire_i          (ret),
    .flush_i               (flush),
    .cap_inflight_o        (inflight),
    .cap_issued_count_o    (issued),
    .stall_cycles_o        (stall),
    .retire_underflow_o    (unf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input uop_tag_t t0, input uop_tag_t t1, input uop_tag_t t2,
                       input uop_tag_t t3, input logic [2:0] cnt);
    duops[0] = t0;
    duops[1] = t1;
    duops[2] = t2;
    duops[3] = t3;
    dcnt     = cnt;
    dv       = 1'b1;
  endtask

  task automatic push(input uop_tag_t t0, input uop_tag_t t1, input uop_tag_t t2,
                      input uop_tag_t t3, input logic [3:0] lv, input logic [3:0] cm);
    exp_t e;
    e.u  = {t3, t2, t1, t0};
    e.lv = lv;
    e.cm = cm;
    exp_q.push_back(e);
  endtask

  // Monitor: one bundle leaves per cycle where valid & ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && disp_v && disp_rdy) begin
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_dispatch: got bundle %h, expected none (t=%0t)", disp_uops, $time);
        end else begin
          e = exp_q.pop_front();
          chk("dispatch_uops", 32'(disp_uops), 32'(e.u));
          chk("dispatch_lane_valid", 32'(disp_lv), 32'(e.lv));
          chk("dispatch_cap_mask", 32'(disp_cap), 32'(e.cm));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dv = 1'b0; dcnt = '0; disp_rdy = 1'b0; ret = '0; flush = 1'b0;
    for (int i = 0; i < 4; i++) duops[i] = UOP_NOP;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", 32'(rr), 0);
    chk("rst_disp_valid", 32'(disp_v), 0);
    chk("rst_lane_valid", 32'(disp_lv), 0);
    chk("rst_cap_mask", 32'(disp_cap), 0);
    chk("rst_uops", 32'(disp_uops), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_issued", 32'(issued), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_underflow", 32'(unf), 0);
    rst = 1'b0;
    #1 chk("idle_ready", 32'(rr), 1);
    repeat (2) tick();
    chk("idle_disp_valid", 32'(disp_v), 0);
    chk("idle_inflight", 32'(inflight), 0);
    chk("idle_stall", 32'(stall), 0);
    chk("idle_ready2", 32'(rr), 1);

    // Partial bundle, lane 3 ignored
    disp_rdy = 1'b1;
    drive(UOP_CAP_JUMP, UOP_ALU, UOP_LINK, UOP_CAP_RET, 3'd3);
    push(UOP_CAP_JUMP, UOP_ALU, UOP_LINK, UOP_NOP, 4'b0111, 4'b0101);
    #1 chk("first_ready", 32'(rr), 1);
    tick(); dv = 1'b0;
    chk("first_disp_valid", 32'(disp_v), 1);
    chk("first_lane_valid", 32'(disp_lv), 32'h7);
    chk("first_cap_mask", 32'(disp_cap), 32'h5);
    chk("first_inflight", 32'(inflight), 2);
    chk("first_issued", 32'(issued), 2);

    // Fill to inflight 7; count 7 clamps to all lanes
    drive(UOP_PREFIX_SELECT, UOP_PREFIX_CANCEL, UOP_CAP_CLONE_RESTRICT, UOP_CAP_LOAN_BEGIN, 3'd4);
    push(UOP_PREFIX_SELECT, UOP_PREFIX_CANCEL, UOP_CAP_CLONE_RESTRICT, UOP_CAP_LOAN_BEGIN, 4'b1111, 4'b1111);
    tick();
    chk("fill_inflight6", 32'(inflight), 6);
    drive(UOP_CAP_LOAN_END, UOP_ALU, UOP_LOAD, UOP_STORE, 3'd7);
    push(UOP_CAP_LOAN_END, UOP_ALU, UOP_LOAD, UOP_STORE, 4'b1111, 4'b0001);
    tick(); dv = 1'b0;
    chk("fill_inflight7", 32'(inflight), 7);
    chk("fill_issued7", 32'(issued), 7);

    // Credit stall, then same-cycle retire credit
    drive(UOP_CAP_JUMP, UOP_CAP_RET, UOP_ALU, UOP_NOP, 3'd3);
    #1 chk("credit_block_ready", 32'(rr), 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("credit_stall_count", 32'(stall), 32'(k));
      chk("credit_stall_ready", 32'(rr), 0);
      chk("credit_stall_inflight", 32'(inflight), 7);
    end
    ret = 3'd1;
    push(UOP_CAP_JUMP, UOP_CAP_RET, UOP_ALU, UOP_NOP, 4'b0111, 4'b0011);
    #1 chk("retire_credit_ready", 32'(rr), 1);
    tick(); dv = 1'b0; ret = '0;
    chk("retire_credit_inflight", 32'(inflight), 8);
    chk("retire_credit_issued", 32'(issued), 9);
    chk("retire_credit_stall", 32'(stall), 3);

    // Drain budget
    ret = 3'd4;
    tick(); chk("drain_inflight4", 32'(inflight), 4);
    tick(); chk("drain_inflight0", 32'(inflight), 0);
    ret = '0;
    chk("drain_no_underflow", 32'(unf), 0);

    // Dispatch back-pressure holds bundle A
    disp_rdy = 1'b0;
    drive(UOP_LINK, UOP_ALU, UOP_NOP, UOP_NOP, 3'd2);
    push(UOP_LINK, UOP_ALU, UOP_NOP, UOP_NOP, 4'b0011, 4'b0001);
    #1 chk("bp_a_ready", 32'(rr), 1);
    tick();
    drive(UOP_STORE, UOP_CAP_JUMP, UOP_ALU, UOP_BRANCH, 3'd4);
    #1 chk("bp_b_ready", 32'(rr), 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("bp_stall", 32'(stall), 32'(3 + k));
      chk("bp_ready", 32'(rr), 0);
      chk("bp_hold_valid", 32'(disp_v), 1);
      chk("bp_hold_lane_valid", 32'(disp_lv), 32'h3);
      chk("bp_hold_cap_mask", 32'(disp_cap), 32'h1);
      chk("bp_hold_uops", 32'(disp_uops), {16'h0, UOP_NOP, UOP_NOP, UOP_ALU, UOP_LINK});
    end

    // Release: B, C, D back-to-back
    push(UOP_STORE, UOP_CAP_JUMP, UOP_ALU, UOP_BRANCH, 4'b1111, 4'b0010);
    disp_rdy = 1'b1;
    #1 chk("b2b_ready_b", 32'(rr), 1);
    tick();
    drive(UOP_CAP_LOAN_BEGIN, UOP_CAP_LOAN_END, UOP_CAP_RET, UOP_CAP_JUMP, 3'd2);
    push(UOP_CAP_LOAN_BEGIN, UOP_CAP_LOAN_END, UOP_NOP, UOP_NOP, 4'b0011, 4'b0011);
    chk("b2b_valid_b", 32'(disp_v), 1);
    #1 chk("b2b_ready_c", 32'(rr), 1);
    tick();
    drive(UOP_ALU, UOP_ALU, UOP_ALU, UOP_PREFIX_SELECT, 3'd4);
    push(UOP_ALU, UOP_ALU, UOP_ALU, UOP_PREFIX_SELECT, 4'b1111, 4'b1000);
    chk("b2b_valid_c", 32'(disp_v), 1);
    #1 chk("b2b_ready_d", 32'(rr), 1);
    tick(); dv = 1'b0;
    chk("b2b_valid_d", 32'(disp_v), 1);
    chk("b2b_inflight", 32'(inflight), 5);
    chk("b2b_issued", 32'(issued), 14);
    tick();
    chk("b2b_drained", 32'(disp_v), 0);

    // Empty bundle accepted, nothing dispatched or counted
    drive(UOP_CAP_JUMP, UOP_CAP_JUMP, UOP_CAP_JUMP, UOP_CAP_JUMP, 3'd0);
    #1 chk("empty_ready", 32'(rr), 1);
    tick(); dv = 1'b0;
    chk("empty_disp_valid", 32'(disp_v), 0);
    chk("empty_lane_valid", 32'(disp_lv), 0);
    chk("empty_inflight", 32'(inflight), 5);
    chk("empty_issued", 32'(issued), 14);

    // Retire underflow is sticky
    ret = 3'd2;
    tick(); chk("unf_inflight3", 32'(inflight), 3);
    chk("unf_clear", 32'(unf), 0);
    ret = 3'd4;
    tick(); chk("unf_inflight0", 32'(inflight), 0);
    chk("unf_set", 32'(unf), 1);
    ret = '0;
    repeat (3) tick();
    chk("unf_sticky", 32'(unf), 1);

    // Run issued count up to 16'hFFFE with steady 4-in/4-out traffic
    drive(UOP_PREFIX_SELECT, UOP_CAP_RET, UOP_LINK, UOP_CAP_JUMP, 3'd4);
    for (int k = 0; k < 16380; k++) begin
      push(UOP_PREFIX_SELECT, UOP_CAP_RET, UOP_LINK, UOP_CAP_JUMP, 4'b1111, 4'b1111);
      tick();
      ret = 3'd4;
    end
    dv = 1'b0;
    tick(); ret = '0;
    chk("sat_pre_inflight", 32'(inflight), 0);
    chk("sat_pre_issued", 32'(issued), 32'hFFFE);

    // Saturating add, bundle E then held
    disp_rdy = 1'b0;
    drive(UOP_CAP_LOAN_BEGIN, UOP_CAP_LOAN_END, UOP_CAP_CLONE_RESTRICT, UOP_PREFIX_CANCEL, 3'd4);
    push(UOP_CAP_LOAN_BEGIN, UOP_CAP_LOAN_END, UOP_CAP_CLONE_RESTRICT, UOP_PREFIX_CANCEL, 4'b1111, 4'b1111);
    #1 chk("sat_ready", 32'(rr), 1);
    tick();
    chk("sat_issued", 32'(issued), 32'hFFFF);
    chk("sat_inflight", 32'(inflight), 4);
    chk("sat_disp_valid", 32'(disp_v), 1);

    // Flush drops held E and refuses new bundle
    drive(UOP_CAP_JUMP, UOP_ALU, UOP_NOP, UOP_NOP, 3'd2);
    flush = 1'b1;
    #1 chk("flush_ready", 32'(rr), 0);
    tick(); flush = 1'b0; dv = 1'b0;
    void'(exp_q.pop_back());
    chk("flush_disp_valid", 32'(disp_v), 0);
    chk("flush_lane_valid", 32'(disp_lv), 0);
    chk("flush_cap_mask", 32'(disp_cap), 0);
    chk("flush_inflight", 32'(inflight), 0);
    chk("flush_issued", 32'(issued), 32'hFFFF);
    chk("flush_stall", 32'(stall), 8);
    chk("flush_underflow", 32'(unf), 1);

    // Reset clears sticky flag and counters
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rst2_underflow", 32'(unf), 0);
    chk("rst2_issued", 32'(issued), 0);
    chk("rst2_stall", 32'(stall), 0);
    chk("scoreboard_left", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
